// File: rtl/iscas_bist_ctrl.sv
// LFSR/MISR built-in self-test controller for ISCAS89 benchmark cores.
// Optional macro BIST_DUT_CE_EN adds a dut_ce output that is high only in WARM and RUN.
module iscas_bist_ctrl #(
  parameter int              IN_W      = 35,
  parameter int              OUT_W     = 23,
  parameter logic [IN_W-1:0] LFSR_TAPS = 35'h5_0000_0000,
  parameter logic [IN_W-1:0] LFSR_SEED = {{(IN_W-1){1'b0}}, 1'b1},
  parameter logic [OUT_W-1:0] MISR_TAPS = 23'h42_0000,
  parameter int              CNT_W     = 16,
  parameter int              WARMUP    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_patterns,
  input  logic [OUT_W-1:0] golden,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] signature,
  output logic             pass
`ifdef BIST_DUT_CE_EN
  ,
  output logic             dut_ce
`endif
);

  // The warm-up counter counts up to WARMUP, so it needs room for that value.
  localparam int WARM_W    = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam int WARM_LAST = (WARMUP > 0) ? WARMUP - 1 : 0;

  typedef enum logic [2:0] {IDLE, SEED, WARM, RUN, DONE} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [IN_W-1:0]     lfsr;
  logic [OUT_W-1:0]    misr;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    npat;
  logic [WARM_W-1:0]   warm;
  logic [IN_W-1:0]     lfsr_next;
  logic [OUT_W-1:0]    misr_next;

  if (LFSR_SEED == '0) begin : g_seed_check
    $error("iscas_bist_ctrl: LFSR_SEED must be nonzero");
  end

  assign lfsr_next = {lfsr[IN_W-2:0], ^(lfsr & LFSR_TAPS)};
  assign misr_next = {misr[OUT_W-2:0], ^(misr & MISR_TAPS)} ^ dut_out;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = SEED;
      SEED: begin
        if (WARMUP > 0)        state_nxt = WARM;
        else if (npat != '0)   state_nxt = RUN;
        else                   state_nxt = DONE;
      end
      WARM: if (warm == WARM_LAST[WARM_W-1:0]) state_nxt = (npat != '0) ? RUN : DONE;
      RUN:  if (cnt == npat - CNT_W'(1)) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lfsr  <= '0;
      misr  <= '0;
      cnt   <= '0;
      warm  <= '0;
      npat  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef BIST_DUT_CE_EN
      dut_ce <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == SEED) || (state_nxt == WARM) || (state_nxt == RUN);
      done  <= (state_nxt == DONE);
`ifdef BIST_DUT_CE_EN
      dut_ce <= (state_nxt == WARM) || (state_nxt == RUN);
`endif
      case (state)
        IDLE, DONE: if (start) npat <= num_patterns;
        SEED: begin
          lfsr <= LFSR_SEED;
          misr <= '0;
          cnt  <= '0;
          warm <= '0;
        end
        WARM: begin
          lfsr <= lfsr_next;
          warm <= warm + 1'b1;
        end
        RUN: begin
          lfsr <= lfsr_next;
          misr <= misr_next;
          cnt  <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign dut_in    = lfsr;
  assign signature = misr;
  assign pass      = done && (signature == golden);

endmodule

// File: tb/tb_iscas_bist_ctrl.sv
// Self-checking bench for iscas_bist_ctrl: one instance with WARMUP=4, one with WARMUP=0,
// both checked cycle by cycle against a latency/LFSR/MISR reference model.
module tb_iscas_bist_ctrl;

  localparam int IN_W  = 35;
  localparam int OUT_W = 23;
  localparam int CNT_W = 16;
  localparam logic [IN_W-1:0]  LTAPS  = 35'h5_0000_0000;
  localparam logic [IN_W-1:0]  SEED_V = 35'h1;
  localparam logic [OUT_W-1:0] MTAPS  = 23'h42_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             start_a   [2];
  logic [CNT_W-1:0] npat_a    [2];
  logic [OUT_W-1:0] golden_a  [2];
  logic [OUT_W-1:0] dut_out_a [2];
  logic [OUT_W-1:0] sig_a     [2];
  logic [IN_W-1:0]  dut_in_a  [2];
  logic             busy_a    [2];
  logic             done_a    [2];
  logic             pass_a    [2];
`ifdef BIST_DUT_CE_EN
  logic             ce_a      [2];
`endif

  for (genvar g = 0; g < 2; g++) begin : g_dut
    iscas_bist_ctrl #(
      .IN_W(IN_W), .OUT_W(OUT_W), .LFSR_TAPS(LTAPS), .LFSR_SEED(SEED_V),
      .MISR_TAPS(MTAPS), .CNT_W(CNT_W), .WARMUP((g == 0) ? 4 : 0)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .start(start_a[g]),
      .num_patterns(npat_a[g]),
      .golden(golden_a[g]),
      .dut_in(dut_in_a[g]),
      .dut_out(dut_out_a[g]),
      .busy(busy_a[g]),
      .done(done_a[g]),
      .signature(sig_a[g]),
      .pass(pass_a[g])
`ifdef BIST_DUT_CE_EN
      ,
      .dut_ce(ce_a[g])
`endif
    );
  end

  int checks = 0;
  int passes = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
  endtask

  // One run: start is sampled at the next edge; cycle k after that edge is SEED for k=1,
  // WARM/RUN for 2..1+W+n, and DONE at k=2+W+n. mode 0=random dut_out, 1=loopback, 2=constant 1.
  task automatic applyStimulus(input int idx, input int n, input int mode, input bit hold);
    int w;
    int last;
    logic [IN_W-1:0]  lfsr_m;
    logic [OUT_W-1:0] misr_m;
    logic [OUT_W-1:0] d;
    w = (idx == 0) ? 4 : 0;
    last = 2 + w + n;
    lfsr_m = '0;
    misr_m = '0;
    start_a[idx] = 1'b1;
    npat_a[idx]  = n[CNT_W-1:0];
    @(posedge clk);
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      if (!hold) start_a[idx] = 1'b0;
      npat_a[idx] = CNT_W'($urandom);
      if (k == 2) lfsr_m = SEED_V;
      if (k < last) begin
        golden_a[idx] = misr_m;
        #1;
        checkOutput("busy", busy_a[idx], 1);
        checkOutput("done", done_a[idx], 0);
        checkOutput("pass_busy", pass_a[idx], 0);
`ifdef BIST_DUT_CE_EN
        checkOutput("dut_ce", ce_a[idx], (k >= 2) ? 1 : 0);
`endif
        if (k >= 2) begin
          checkOutput("dut_in", dut_in_a[idx], lfsr_m);
          checkOutput("sig_busy", sig_a[idx], misr_m);
        end
        d = OUT_W'($urandom);
        if (mode == 1) d = dut_in_a[idx][OUT_W-1:0];
        if (mode == 2) d = 1;
        dut_out_a[idx] = d;
        if (k >= 2 + w)
          misr_m = {misr_m[OUT_W-2:0], ^(misr_m & MTAPS)} ^ d;
        if (k >= 2)
          lfsr_m = {lfsr_m[IN_W-2:0], ^(lfsr_m & LTAPS)};
      end else begin
        checkOutput("busy_done", busy_a[idx], 0);
        checkOutput("done", done_a[idx], 1);
        checkOutput("dut_in_done", dut_in_a[idx], lfsr_m);
        checkOutput("signature", sig_a[idx], misr_m);
`ifdef BIST_DUT_CE_EN
        checkOutput("dut_ce_done", ce_a[idx], 0);
`endif
        golden_a[idx] = misr_m;
        #1;
        checkOutput("pass_match", pass_a[idx], 1);
        golden_a[idx] = misr_m ^ (OUT_W'(1) << $urandom_range(0, OUT_W - 1));
        #1;
        checkOutput("pass_miss", pass_a[idx], 0);
      end
    end
  endtask

  task automatic checkResetState(input string tag);
    for (int i = 0; i < 2; i++) begin
      golden_a[i] = '0;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput({tag, "_dut_in"}, dut_in_a[i], 0);
      checkOutput({tag, "_sig"}, sig_a[i], 0);
      checkOutput({tag, "_busy"}, busy_a[i], 0);
      checkOutput({tag, "_done"}, done_a[i], 0);
      checkOutput({tag, "_pass"}, pass_a[i], 0);
`ifdef BIST_DUT_CE_EN
      checkOutput({tag, "_ce"}, ce_a[i], 0);
`endif
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_a[i] = 1'b0;
      npat_a[i] = '0;
      golden_a[i] = '0;
      dut_out_a[i] = '0;
    end
    repeat (2) @(negedge clk);
    checkResetState("reset");
    rst = 1'b0;
    @(negedge clk);
    checkResetState("idle");

    applyStimulus(1, 0, 0, 1'b0);
    applyStimulus(1, 2, 2, 1'b0);
    applyStimulus(0, 3, 1, 1'b0);
    applyStimulus(0, 5, 0, 1'b1);
    applyStimulus(0, 4, 0, 1'b1);
    start_a[0] = 1'b0;

    for (int r = 0; r < 12; r++) begin
      int idx;
      bit hold;
      idx = $urandom_range(0, 1);
      hold = 1'($urandom_range(0, 1));
      applyStimulus(idx, $urandom_range(0, 20), $urandom_range(0, 2), hold);
      start_a[idx] = 1'b0;
    end
    applyStimulus(1, 300, 0, 1'b0);

    // Reset in the middle of a run on the warm-up instance.
    start_a[0] = 1'b1;
    npat_a[0] = 16'd10;
    @(posedge clk);
    @(negedge clk);
    start_a[0] = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkResetState("midrun_rst");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkResetState("after_rst");

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
